fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//  Sequences the IF-stage program counter of the RV32IM pipeline. Each cycle it picks the next fetch address:
//  sequential PC+4, JAL target from ID, branch/JALR target from EX, or hold.
//  Handshakes with the instruction cache via busywait and holds a redirect that arrives while a fetch is stalled.
//  Generates the IF/ID and ID/EX flush strobes.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  first fetch address after reset
//  TRAP_VECTOR   32'h0000_0100  misaligned-target trap handler (used only with FETCH_MISALIGN_TRAP_EN)
// PORTS
//  CLOCK          in   1   system clock, rising edge
//  RESET          in   1   synchronous, active-high
//  IMEM_BUSYWAIT  in   1   icache stall; fetch at PC_OUT not complete
//  STALL_HAZARD   in   1   load-use stall from hazard unit; hold PC
//  JUMP_VALID     in   1   JAL resolved in ID
//  JUMP_TARGET    in   32  JAL target
//  BRANCH_TAKEN   in   1   taken branch or JALR resolved in EX
//  BRANCH_TARGET  in   32  branch/JALR target
//  PC_OUT         out  32  current fetch address to icache and IF/ID
//  PC_PLUS4       out  32  PC_OUT+4 (link value), combinational
//  IMEM_READ      out  1   fetch request
//  FETCH_VALID    out  1   IF/ID write-enable with valid instruction
//  FLUSH_IFID     out  1   squash IF/ID
//  FLUSH_IDEX     out  1   squash ID/EX
//  TRAP_O         out  1   1-cycle misaligned-target trap pulse
//  TRAP_ADDR      out  32  offending target, held until next trap
// BEHAVIOUR
//  Reset values: PC_OUT=RESET_VECTOR, IMEM_READ=0, FETCH_VALID=0, FLUSH_*=0, TRAP_O=0, TRAP_ADDR=0, state BOOT.
//  Any pending redirect is discarded, including on reset during busywait.
//  FSM:
//   BOOT: one cycle after RESET falls; IMEM_READ=0; goes to RUN.
//   RUN: IMEM_READ=1.
//    - busywait=1: go to WAIT.
//    - redirect with busywait=1: go to PEND.
//   WAIT: PC held; go to RUN when busywait=0.
//   PEND: redirect target latched in PEND_PC.
//    - When busywait=0: PC_OUT<=PEND_PC on that edge, go to RUN.
//  Next-PC priority, registered on the edge:
//   1. BRANCH_TAKEN → BRANCH_TARGET
//   2. JUMP_VALID → JUMP_TARGET
//   3. STALL_HAZARD or busywait → hold
//   4. otherwise PC_OUT+4
//  Flushes are combinational in the cycle the redirect is accepted, whether or not busywait is high:
//   - branch asserts FLUSH_IFID and FLUSH_IDEX;
//   - jump asserts FLUSH_IFID only.
//  Branch and jump in the same cycle: branch wins, jump dropped.
//  Redirect beats STALL_HAZARD.
//  While in PEND:
//   - a new BRANCH_TAKEN overwrites PEND_PC and flushes again;
//   - JUMP_VALID is ignored (wrong path).
//  FETCH_VALID = IMEM_READ & !IMEM_BUSYWAIT & !STALL_HAZARD & !FLUSH_IFID; it is 0 in BOOT and PEND.
//  Arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0, no flag.
// CONFIGURATION
//  FETCH_MISALIGN_TRAP_EN defined:
//   - a redirect target with [1:0]!=0 loads PC_OUT<=TRAP_VECTOR;
//   - TRAP_O pulses 1 cycle and TRAP_ADDR<=target;
//   - flushes as for a branch.
//  Undefined: target[1:0] forced to 2'b00; TRAP_O=0 and TRAP_ADDR=0 constant.
// STRUCTURE
//  Shared header fetch_defs.vh: FSM state encodings (BOOT/RUN/WAIT/PEND, 2-bit) and RESET_VECTOR/TRAP_VECTOR defaults.
//  Sub-module next_pc_mux: combinational priority select of next PC and redirect kind.
//  FSM, PC_OUT, PEND_PC and trap registers live in fetch_sequencer.
// TESTING
//  1. RESET 3 cycles, release, busywait=0 → BOOT 1 cycle; then PC_OUT 0,4,8,...; FETCH_VALID=1 from cycle 2.
//  2. BRANCH_TAKEN=1, target 0x40, at PC=0x10 → FLUSH_IFID=FLUSH_IDEX=1 that cycle; next PC_OUT=0x40.
//  3. BRANCH (0x80) and JUMP (0x20) in the same cycle → PC_OUT=0x80; both flushes asserted.
//  4. busywait 4 cycles; JUMP to 0x200 in cycle 2 → FLUSH_IFID in cycle 2; PC_OUT=0x200 on the edge busywait drops.
//  5. PEND with target 0x200, then BRANCH to 0x300 → 0x300 wins; RESET during PEND → PC_OUT=RESET_VECTOR, pending lost.
//  6. [TRAP_EN] BRANCH to 0x102 → PC_OUT=0x100, TRAP_O=1 for 1 cycle, TRAP_ADDR=0x102. [no macro] PC_OUT=0x100, TRAP_O=0.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and defaults for the IF-stage fetch sequencer.
// FSM state encodings are 2-bit; the default vectors feed the top-level parameters.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        StBoot = 2'b00,
        StRun  = 2'b01,
        StWait = 2'b10,
        StPend = 2'b11
    } fetch_state_e;

    typedef enum logic [1:0] {
        RedirNone   = 2'b00,
        RedirJump   = 2'b01,
        RedirBranch = 2'b10
    } redir_e;

    localparam logic [31:0] DefaultResetVector = 32'h0000_0000;
    localparam logic [31:0] DefaultTrapVector  = 32'h0000_0100;

    // Clear the two low bits so a fetch address is always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_sequencer_next_pc_mux.sv
// Combinational priority select for the fetch sequencer:
// branch/JALR beats JAL; without a redirect the PC holds or advances by 4.
module fetch_sequencer_next_pc_mux
    import fetch_sequencer_pkg::*;
(
    input  logic        branch_valid_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_valid_i,
    input  logic [31:0] jump_target_i,
    input  logic        hold_i,
    input  logic [31:0] pc_i,
    output redir_e      redir_kind_o,
    output logic [31:0] redir_target_o,
    output logic [31:0] fallthrough_pc_o,
    output logic [31:0] pc_plus4_o
);

    // Pick the redirect source and the non-redirect fall-through address.
    always_comb begin
        redir_kind_o     = RedirNone;
        redir_target_o   = branch_target_i;
        pc_plus4_o       = pc_i + 32'd4;
        fallthrough_pc_o = hold_i ? pc_i : pc_plus4_o;
        if (branch_valid_i) begin
            redir_kind_o   = RedirBranch;
            redir_target_o = branch_target_i;
        end else if (jump_valid_i) begin
            redir_kind_o   = RedirJump;
            redir_target_o = jump_target_i;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage program-counter sequencer for the RV32IM pipeline.
// Handles icache busywait, parks a redirect that arrives mid-stall, and drives the
// IF/ID and ID/EX flush strobes.
// Optional feature: define FETCH_MISALIGN_TRAP_EN to trap on misaligned redirect targets;
// otherwise targets are silently word aligned.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DefaultResetVector,
    parameter logic [31:0] TRAP_VECTOR  = DefaultTrapVector
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        IMEM_BUSYWAIT,
    input  logic        STALL_HAZARD,
    input  logic        JUMP_VALID,
    input  logic [31:0] JUMP_TARGET,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic [31:0] PC_OUT,
    output logic [31:0] PC_PLUS4,
    output logic        IMEM_READ,
    output logic        FETCH_VALID,
    output logic        FLUSH_IFID,
    output logic        FLUSH_IDEX,
    output logic        TRAP_O,
    output logic [31:0] TRAP_ADDR
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pend_pc_q, pend_pc_d;

    redir_e       redir_kind;
    logic [31:0]  redir_target;
    logic [31:0]  redir_pc;
    logic [31:0]  fallthrough_pc;
    logic         redirect;
    logic         branch_en;
    logic         jump_en;

    // No redirects in BOOT (pipeline empty); JAL in PEND is on the wrong path.
    assign branch_en = BRANCH_TAKEN & (state_q != StBoot);
    assign jump_en   = JUMP_VALID & (state_q != StBoot) & (state_q != StPend);

    fetch_sequencer_next_pc_mux u_next_pc_mux (
        .branch_valid_i   (branch_en),
        .branch_target_i  (BRANCH_TARGET),
        .jump_valid_i     (jump_en),
        .jump_target_i    (JUMP_TARGET),
        .hold_i           (STALL_HAZARD | IMEM_BUSYWAIT),
        .pc_i             (pc_q),
        .redir_kind_o     (redir_kind),
        .redir_target_o   (redir_target),
        .fallthrough_pc_o (fallthrough_pc),
        .pc_plus4_o       (PC_PLUS4)
    );

    assign redirect = (redir_kind != RedirNone);

`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misaligned;
    logic        trap_q;
    logic [31:0] trap_addr_q;

    assign misaligned = redirect & (redir_target[1:0] != 2'b00);
    assign redir_pc   = misaligned ? TRAP_VECTOR : redir_target;
    assign FLUSH_IDEX = (redir_kind == RedirBranch) | misaligned;
    assign TRAP_O     = trap_q;
    assign TRAP_ADDR  = trap_addr_q;

    // Trap pulse and offending-target capture, taken when the redirect is accepted.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            trap_q      <= 1'b0;
            trap_addr_q <= 32'h0;
        end else begin
            trap_q <= misaligned;
            if (misaligned) begin
                trap_addr_q <= redir_target;
            end
        end
    end
`else
    assign redir_pc   = word_align(redir_target);
    assign FLUSH_IDEX = (redir_kind == RedirBranch);
    assign TRAP_O     = 1'b0;
    assign TRAP_ADDR  = 32'h0;
`endif

    assign PC_OUT      = pc_q;
    assign IMEM_READ   = (state_q != StBoot);
    assign FLUSH_IFID  = redirect;
    assign FETCH_VALID = IMEM_READ & ~IMEM_BUSYWAIT & ~STALL_HAZARD & ~FLUSH_IFID &
                         (state_q != StPend);

    // Next-state and next-PC selection.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        unique case (state_q)
            StBoot: begin
                state_d = StRun;
            end
            StRun, StWait: begin
                if (redirect) begin
                    if (IMEM_BUSYWAIT) begin
                        state_d   = StPend;
                        pend_pc_d = redir_pc;
                    end else begin
                        state_d = StRun;
                        pc_d    = redir_pc;
                    end
                end else if (IMEM_BUSYWAIT) begin
                    state_d = StWait;
                end else begin
                    state_d = StRun;
                    pc_d    = fallthrough_pc;
                end
            end
            StPend: begin
                // A newer branch supersedes the parked target.
                if (redirect) begin
                    if (IMEM_BUSYWAIT) begin
                        pend_pc_d = redir_pc;
                    end else begin
                        state_d = StRun;
                        pc_d    = redir_pc;
                    end
                end else if (!IMEM_BUSYWAIT) begin
                    state_d = StRun;
                    pc_d    = pend_pc_q;
                end
            end
            default: begin
                state_d = StBoot;
            end
        endcase
    end

    // State, PC and parked-redirect registers; reset discards any pending redirect.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q   <= StBoot;
            pc_q      <= RESET_VECTOR;
            pend_pc_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
        end
    end

endmodule
